min_detect_cbfp_blk: RTL and testbench

- Parametrised CBFP minimum-leading-zero detector for the FFT datapath.
- Reduces NUM_LANES LZC values per path per beat, per path, with a registered min tree.
- Accumulates the per-beat minima over a block of BLK_BEATS valid beats.
- Emits one shared block-exponent candidate per path with a single-cycle valid pulse, which drives the CBFP scaling stage.

---
 rtl/min_detect_cbfp_blk.sv | 110 +++++++++++
 tb/tb_min_detect_cbfp_blk.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/min_detect_cbfp_blk.sv
// CBFP minimum-leading-zero detector: a registered per-beat lane minimum tree followed by
// block accumulation that emits one exponent candidate per path with a one-cycle valid pulse.
module min_detect_cbfp_blk #(
  parameter int LZC_WIDTH = 5,
  parameter int NUM_LANES = 16,
  parameter int NUM_PATHS = 2,
  parameter int BLK_BEATS = 4,
  parameter int CNT_W     = $clog2(BLK_BEATS) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 mode_joint,
  input  logic                 in_valid,
  input  logic [LZC_WIDTH-1:0] lzc_in  [0:NUM_PATHS-1][0:NUM_LANES-1],
  output logic [LZC_WIDTH-1:0] min_out [0:NUM_PATHS-1],
  output logic                 out_valid,
  output logic [CNT_W-1:0]     beat_cnt
);

  localparam int LVLS = $clog2(NUM_LANES);

  logic [LZC_WIDTH-1:0] w_laneMin [0:NUM_PATHS-1];
  logic [LZC_WIDTH-1:0] w_blk     [0:NUM_PATHS-1];
  logic [LZC_WIDTH-1:0] w_joint;
  logic                 w_last;

  logic [LZC_WIDTH-1:0] r_s1Min   [0:NUM_PATHS-1];
  logic [LZC_WIDTH-1:0] r_acc     [0:NUM_PATHS-1];
  logic [LZC_WIDTH-1:0] r_minOut  [0:NUM_PATHS-1];
  logic                 r_validS1;
  logic                 r_outValid;
  logic [CNT_W-1:0]     r_beatCnt;

  // Pairwise reduction done in place; an odd trailing node is copied up unchanged.
  always_comb begin : laneTree
    logic [LZC_WIDTH-1:0] w_node [0:2*NUM_LANES-1];
    int n;
    for (int p = 0; p < NUM_PATHS; p++) begin
      w_laneMin[p] = '0;
      for (int i = 0; i < 2*NUM_LANES; i++) w_node[i] = '1;
      for (int i = 0; i < NUM_LANES; i++) w_node[i] = lzc_in[p][i];
      n = NUM_LANES;
      for (int l = 0; l < LVLS; l++) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (i < (n + 1) / 2) begin
            if (2*i + 1 < n)
              w_node[i] = (w_node[2*i+1] < w_node[2*i]) ? w_node[2*i+1] : w_node[2*i];
            else
              w_node[i] = w_node[2*i];
          end
        end
        n = (n + 1) / 2;
      end
      w_laneMin[p] = w_node[0];
    end
  end

  always_comb begin
    w_joint = '1;
    for (int p = 0; p < NUM_PATHS; p++) begin
      w_blk[p] = r_s1Min[p];
      if (r_beatCnt != '0 && r_acc[p] < r_s1Min[p]) w_blk[p] = r_acc[p];
      if (w_blk[p] < w_joint) w_joint = w_blk[p];
    end
  end

  assign w_last = (r_beatCnt == CNT_W'(BLK_BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PATHS; p++) begin
        r_s1Min[p]  <= '0;
        r_acc[p]    <= '0;
        r_minOut[p] <= '0;
      end
      r_validS1  <= 1'b0;
      r_outValid <= 1'b0;
      r_beatCnt  <= '0;
    end else if (clear) begin
      // Both the incoming beat and any block finishing at this edge are dropped.
      r_validS1  <= 1'b0;
      r_outValid <= 1'b0;
      r_beatCnt  <= '0;
    end else begin
      r_validS1 <= in_valid;
      if (in_valid) begin
        for (int p = 0; p < NUM_PATHS; p++) r_s1Min[p] <= w_laneMin[p];
      end
      if (r_validS1) begin
        for (int p = 0; p < NUM_PATHS; p++) r_acc[p] <= w_blk[p];
        if (w_last) begin
          for (int p = 0; p < NUM_PATHS; p++) r_minOut[p] <= mode_joint ? w_joint : w_blk[p];
          r_outValid <= 1'b1;
          r_beatCnt  <= '0;
        end else begin
          r_outValid <= 1'b0;
          r_beatCnt  <= r_beatCnt + CNT_W'(1);
        end
      end else begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign min_out   = r_minOut;
  assign out_valid = r_outValid;
  assign beat_cnt  = r_beatCnt;

endmodule

// File: tb/tb_min_detect_cbfp_blk.sv
// Bench for min_detect_cbfp_blk: directed vector table on the 4-beat instance, a stall
// sequence, and a long random run with 1-, 4- and 5-beat instances against a queue-based model.
module tb_min_detect_cbfp_blk;

  localparam int LW = 5;
  localparam int NL = 16;
  localparam int NP = 2;

  logic          clk = 1'b0;
  logic          rst, clear, modeJoint, inValid;
  logic [LW-1:0] lzcIn [0:NP-1][0:NL-1];

  logic [LW-1:0] minOut1 [0:NP-1];
  logic [LW-1:0] minOut4 [0:NP-1];
  logic [LW-1:0] minOut5 [0:NP-1];
  logic          validOut1, validOut4, validOut5;
  logic [0:0]    cnt1;
  logic [2:0]    cnt4;
  logic [3:0]    cnt5;

  always #5 clk = ~clk;

  min_detect_cbfp_blk #(.BLK_BEATS(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .mode_joint(modeJoint), .in_valid(inValid),
    .lzc_in(lzcIn), .min_out(minOut1), .out_valid(validOut1), .beat_cnt(cnt1));
  min_detect_cbfp_blk #(.BLK_BEATS(4)) dut4 (
    .clk(clk), .rst(rst), .clear(clear), .mode_joint(modeJoint), .in_valid(inValid),
    .lzc_in(lzcIn), .min_out(minOut4), .out_valid(validOut4), .beat_cnt(cnt4));
  min_detect_cbfp_blk #(.BLK_BEATS(5)) dut5 (
    .clk(clk), .rst(rst), .clear(clear), .mode_joint(modeJoint), .in_valid(inValid),
    .lzc_in(lzcIn), .min_out(minOut5), .out_valid(validOut5), .beat_cnt(cnt5));

  typedef struct {
    bit rst, clr, mode, vld;
    int fill, p0Lane, p0Val, p1Lane, p1Val;
    bit expValid;
    int expMin0, expMin1, expCnt;
  } vec_t;

  vec_t vecs[$];
  int   totalChecks = 0;
  int   passChecks  = 0;

  int blkN [3] = '{1, 4, 5};
  int beatQ [3][NP][$];
  bit pendValid [3];
  int pendMin [3][NP];
  bit expValid [3];
  int expMin [3][NP];

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalChecks++;
    if (actual == expected) passChecks++;
    else $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
  endtask

  function automatic int beatMin(input int p);
    int m = 1 << LW;
    for (int l = 0; l < NL; l++) if (int'(lzcIn[p][l]) < m) m = int'(lzcIn[p][l]);
    return m;
  endfunction

  // Model: beats sit one cycle in a pending slot, then join the block list; a full list is reduced.
  task automatic modelStep();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        pendValid[k] = 0;
        expValid[k]  = 0;
        for (int p = 0; p < NP; p++) begin
          beatQ[k][p].delete();
          expMin[k][p] = 0;
        end
      end else if (clear) begin
        pendValid[k] = 0;
        expValid[k]  = 0;
        for (int p = 0; p < NP; p++) beatQ[k][p].delete();
      end else begin
        expValid[k] = 0;
        if (pendValid[k]) begin
          for (int p = 0; p < NP; p++) beatQ[k][p].push_back(pendMin[k][p]);
          if (beatQ[k][0].size() == blkN[k]) begin
            int blk [NP];
            int joint = 1 << LW;
            for (int p = 0; p < NP; p++) begin
              blk[p] = 1 << LW;
              foreach (beatQ[k][p][j]) if (beatQ[k][p][j] < blk[p]) blk[p] = beatQ[k][p][j];
              if (blk[p] < joint) joint = blk[p];
              beatQ[k][p].delete();
            end
            for (int p = 0; p < NP; p++) expMin[k][p] = modeJoint ? joint : blk[p];
            expValid[k] = 1;
          end
        end
        pendValid[k] = inValid;
        if (inValid) for (int p = 0; p < NP; p++) pendMin[k][p] = beatMin(p);
      end
    end
  endtask

  task automatic checkModel();
    int aValid, aCnt;
    int aMin [NP];
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin aValid = validOut1; aCnt = cnt1; for (int p = 0; p < NP; p++) aMin[p] = minOut1[p]; end
        1: begin aValid = validOut4; aCnt = cnt4; for (int p = 0; p < NP; p++) aMin[p] = minOut4[p]; end
        default: begin aValid = validOut5; aCnt = cnt5; for (int p = 0; p < NP; p++) aMin[p] = minOut5[p]; end
      endcase
      checkOutput($sformatf("model N=%0d out_valid", blkN[k]), aValid, int'(expValid[k]));
      checkOutput($sformatf("model N=%0d beat_cnt", blkN[k]), aCnt, beatQ[k][0].size());
      for (int p = 0; p < NP; p++)
        checkOutput($sformatf("model N=%0d min_out[%0d]", blkN[k], p), aMin[p], expMin[k][p]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkModel();
  endtask

  task automatic setBeat(input int fill, input int p0Lane, input int p0Val, input int p1Lane, input int p1Val);
    for (int p = 0; p < NP; p++)
      for (int l = 0; l < NL; l++) lzcIn[p][l] = LW'(fill);
    if (p0Lane >= 0) lzcIn[0][p0Lane] = LW'(p0Val);
    if (p1Lane >= 0) lzcIn[1][p1Lane] = LW'(p1Val);
  endtask

  task automatic addVec(input bit r, input bit c, input bit m, input bit v, input int fill,
                        input int p0L, input int p0V, input int p1L, input int p1V,
                        input bit eV, input int eM0, input int eM1, input int eC);
    vec_t x;
    x.rst = r; x.clr = c; x.mode = m; x.vld = v; x.fill = fill;
    x.p0Lane = p0L; x.p0Val = p0V; x.p1Lane = p1L; x.p1Val = p1V;
    x.expValid = eV; x.expMin0 = eM0; x.expMin1 = eM1; x.expCnt = eC;
    vecs.push_back(x);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    rst = v.rst; clear = v.clr; modeJoint = v.mode; inValid = v.vld;
    setBeat(v.fill, v.p0Lane, v.p0Val, v.p1Lane, v.p1Val);
    tick();
    checkOutput($sformatf("vec%0d out_valid", idx), int'(validOut4), int'(v.expValid));
    checkOutput($sformatf("vec%0d min_out[0]", idx), int'(minOut4[0]), v.expMin0);
    checkOutput($sformatf("vec%0d min_out[1]", idx), int'(minOut4[1]), v.expMin1);
    checkOutput($sformatf("vec%0d beat_cnt", idx), int'(cnt4), v.expCnt);
  endtask

  initial begin
    int gap, base;
    rst = 1; clear = 0; modeJoint = 0; inValid = 0;
    setBeat(0, -1, 0, -1, 0);
    tick();
    tick();

    // Single block, per-path output
    addVec(0,0,0,1, 20,-1,0,15,9,  0, 0, 0,0);
    addVec(0,0,0,1, 20,-1,0,-1,0,  0, 0, 0,1);
    addVec(0,0,0,1, 20, 7,3,-1,0,  0, 0, 0,2);
    addVec(0,0,0,1, 20,-1,0,-1,0,  0, 0, 0,3);
    addVec(0,0,0,0, 20,-1,0,-1,0,  1, 3, 9,0);
    // Same block, joint output
    addVec(0,0,1,1, 20,-1,0,15,9,  0, 3, 9,0);
    addVec(0,0,1,1, 20,-1,0,-1,0,  0, 3, 9,1);
    addVec(0,0,1,1, 20, 7,3,-1,0,  0, 3, 9,2);
    addVec(0,0,1,1, 20,-1,0,-1,0,  0, 3, 9,3);
    addVec(0,0,1,0, 20,-1,0,-1,0,  1, 3, 3,0);
    // Back-to-back blocks, maximum count then zero
    addVec(0,0,1,1, 31,-1,0,-1,0,  0, 3, 3,0);
    addVec(0,0,1,1, 31,-1,0,-1,0,  0, 3, 3,1);
    addVec(0,0,1,1, 31,-1,0,-1,0,  0, 3, 3,2);
    addVec(0,0,1,1, 31,-1,0,-1,0,  0, 3, 3,3);
    addVec(0,0,1,1, 20,-1,0,-1,0,  1,31,31,0);
    addVec(0,0,1,1, 20, 3,0,-1,0,  0,31,31,1);
    addVec(0,0,1,1, 20,-1,0,-1,0,  0,31,31,2);
    addVec(0,0,1,1, 20,-1,0,-1,0,  0,31,31,3);
    addVec(0,0,1,0, 20,-1,0,-1,0,  1, 0, 0,0);
    // Clear mid-block
    addVec(0,0,0,1, 20, 0,1, 0,1,  0, 0, 0,0);
    addVec(0,0,0,1, 20, 0,1, 0,1,  0, 0, 0,1);
    addVec(0,1,0,0, 20,-1,0,-1,0,  0, 0, 0,0);
    addVec(0,0,0,1, 12,-1,0,-1,0,  0, 0, 0,0);
    addVec(0,0,0,1, 12,-1,0,-1,0,  0, 0, 0,1);
    addVec(0,0,0,1, 12,-1,0,-1,0,  0, 0, 0,2);
    addVec(0,0,0,1, 12,-1,0,-1,0,  0, 0, 0,3);
    addVec(0,0,0,0, 12,-1,0,-1,0,  1,12,12,0);
    // Clear on the completing edge, with a beat offered at the same time
    addVec(0,0,0,1, 25,-1,0,-1,0,  0,12,12,0);
    addVec(0,0,0,1, 25,-1,0,-1,0,  0,12,12,1);
    addVec(0,0,0,1, 25,-1,0,-1,0,  0,12,12,2);
    addVec(0,0,0,1, 25,-1,0,-1,0,  0,12,12,3);
    addVec(0,1,0,1,  2,-1,0,-1,0,  0,12,12,0);
    addVec(0,0,0,0, 25,-1,0,-1,0,  0,12,12,0);
    // Reset mid-block, then a fresh block
    addVec(0,0,0,1,  7,-1,0,-1,0,  0,12,12,0);
    addVec(0,0,0,1,  7,-1,0,-1,0,  0,12,12,1);
    addVec(0,0,0,1,  7,-1,0,-1,0,  0,12,12,2);
    addVec(1,0,0,0,  7,-1,0,-1,0,  0, 0, 0,0);
    addVec(0,0,0,1, 10,-1,0, 2,4,  0, 0, 0,0);
    addVec(0,0,0,1, 10,-1,0,-1,0,  0, 0, 0,1);
    addVec(0,0,0,1, 10,-1,0,-1,0,  0, 0, 0,2);
    addVec(0,0,0,1, 10,-1,0,-1,0,  0, 0, 0,3);
    addVec(0,0,0,0, 10,-1,0,-1,0,  1,10, 4,0);

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Same four beats as the first block, separated by random gaps
    rst = 0; clear = 0; modeJoint = 0;
    for (int b = 0; b < 4; b++) begin
      case (b)
        0: setBeat(20, -1, 0, 15, 9);
        2: setBeat(20, 7, 3, -1, 0);
        default: setBeat(20, -1, 0, -1, 0);
      endcase
      inValid = 1;
      tick();
      checkOutput($sformatf("stall beat%0d out_valid", b), int'(validOut4), 0);
      checkOutput($sformatf("stall beat%0d beat_cnt", b), int'(cnt4), b);
      inValid = 0;
      if (b < 3) begin
        gap = $urandom_range(5, 0);
        for (int g = 0; g < gap; g++) begin
          tick();
          checkOutput($sformatf("stall gap%0d out_valid", b), int'(validOut4), 0);
          checkOutput($sformatf("stall gap%0d beat_cnt", b), int'(cnt4), b + 1);
        end
      end
    end
    tick();
    checkOutput("stall pulse out_valid", int'(validOut4), 1);
    checkOutput("stall pulse min_out[0]", int'(minOut4[0]), 3);
    checkOutput("stall pulse min_out[1]", int'(minOut4[1]), 9);
    tick();
    checkOutput("stall after out_valid", int'(validOut4), 0);
    checkOutput("stall hold min_out[1]", int'(minOut4[1]), 9);

    // Random regression on all three block lengths
    rst = 1; inValid = 0;
    tick();
    rst = 0;
    for (int c = 0; c < 10000; c++) begin
      rst       = ($urandom_range(999, 0) == 0);
      clear     = ($urandom_range(63, 0) == 0);
      modeJoint = 1'($urandom_range(1, 0));
      inValid   = ($urandom_range(3, 0) != 0);
      base      = $urandom_range(31, 0);
      for (int p = 0; p < NP; p++)
        for (int l = 0; l < NL; l++) lzcIn[p][l] = LW'($urandom_range(31, base));
      tick();
    end
    rst = 0; clear = 0; inValid = 0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
